// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, FSM states, error codes
// and the alignment rule used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  // Illegal width codes and unsigned stores are folded into the misaligned error.
  function automatic logic is_misaligned(input logic store, input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = offset[0];
      F3_W:    bad = |offset;
      F3_BU:   bad = store;
      F3_HU:   bad = store | offset[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and the store
// read-modify-write merge of new lanes into the word currently in memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rd,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_ext;
  logic signed [31:0] half_ext;

  always_comb begin
    byte_s   = rd[{offset, 3'b000} +: 8];
    half_s   = offset[1] ? rd[31:16] : rd[15:0];
    byte_ext = byte_s;
    half_ext = half_s;
    case (funct3)
      F3_B:    load_data = byte_ext;
      F3_H:    load_data = half_ext;
      F3_BU:   load_data = {24'd0, byte_s};
      F3_HU:   load_data = {16'd0, half_s};
      default: load_data = rd;
    endcase
  end

  always_comb begin
    merged = rd;
    case (funct3)
      F3_B: merged[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      F3_W:    merged = wdata;
      default: merged = rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller for a word-organised data memory:
// IDLE accepts and checks, ACCESS does the one-cycle memory touch, RESP holds the result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic [31:0]           mem_A,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  state_t      state, state_nxt;
  logic [1:0]  req_err;
  logic        accept;

  logic        store_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    if (is_misaligned(req_store, req_funct3, req_addr[1:0])) req_err = ERR_MISALIGN;
    else if (|req_addr[31:ADDR_WIDTH+2])                     req_err = ERR_RANGE;
    else                                                     req_err = ERR_OK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (req_err != ERR_OK) ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_we    = store_p0;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = (state == IDLE) && req_valid;
  assign rsp_valid = (state == RESP);

  // ---- accept stage: request captured into _p0 ----
  always_ff @(posedge clk) begin
    if (accept) begin
      store_p0  <= req_store;
      funct3_p0 <= req_funct3;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
    end
  end

  lsu_align u_align (
    .funct3    (funct3_p0),
    .offset    (addr_p0[1:0]),
    .wdata     (wdata_p0),
    .rd        (mem_RD),
    .load_data (load_data),
    .merged    (merged)
  );

  // Memory outputs are gated by state so they read zero whenever no access is in flight.
  assign mem_A  = (state == ACCESS) ? {{(32-ADDR_WIDTH){1'b0}}, addr_p0[ADDR_WIDTH+1:2]} : 32'd0;
  assign mem_WD = mem_we ? merged : '0;

  // ---- response stage: result registered at the close of ACCESS (or at accept on error) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else if (accept) begin
      rsp_rdata <= '0;
      rsp_err   <= req_err;
    end else if (state == ACCESS) begin
      rsp_rdata <= store_p0 ? '0 : load_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory attached.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_A;
  logic        mem_we;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:31];
  int          passes = 0;
  int          total  = 0;

  load_store_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_A      (mem_A),
    .mem_we     (mem_we),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) mem[i] = 32'd0;
  always @(posedge clk) if (mem_we) mem[mem_A[4:0]] <= mem_WD;
  assign mem_RD = mem[mem_A[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One complete transaction; error requests skip the ACCESS cycle.
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input logic [1:0] exp_err, input int hold);
    @(negedge clk);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_err == ERR_OK) begin
      check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, st});
      check({tag, ".mem_A"}, mem_A, {2'b00, a[31:2]});
      if (st) check({tag, ".mem_WD"}, mem_WD, exp_wd);
      check({tag, ".early_valid"}, {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end else begin
      check({tag, ".no_we"}, {31'd0, mem_we}, 32'd0);
    end
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".rsp_err"}, {30'd0, rsp_err}, {30'd0, exp_err});
    check({tag, ".rsp_rdata"}, rsp_rdata, exp_rd);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, ".hold_err"}, {30'd0, rsp_err}, {30'd0, exp_err});
      check({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".rsp_clear"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", {30'd0, rsp_err}, 32'd0);
    check("rst.mem_we", {31'd0, mem_we}, 32'd0);
    check("rst.mem_A", mem_A, 32'd0);
    check("rst.mem_WD", mem_WD, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);

    do_req("sw08", 1'b1, F3_W, 32'h08, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, ERR_OK, 0);
    check("sw08.mem2", mem[2], 32'hDEADBEEF);
    do_req("lw08", 1'b0, F3_W, 32'h08, 32'd0, 32'd0, 32'hDEADBEEF, ERR_OK, 0);

    do_req("sb09", 1'b1, F3_B, 32'h09, 32'h00000055, 32'hDEAD55EF, 32'd0, ERR_OK, 0);
    check("sb09.mem2", mem[2], 32'hDEAD55EF);
    do_req("lb09", 1'b0, F3_B, 32'h09, 32'd0, 32'd0, 32'h00000055, ERR_OK, 0);
    do_req("lb0b", 1'b0, F3_B, 32'h0B, 32'd0, 32'd0, 32'hFFFFFFDE, ERR_OK, 0);
    do_req("lbu0b", 1'b0, F3_BU, 32'h0B, 32'd0, 32'd0, 32'h000000DE, ERR_OK, 0);

    do_req("lh0a", 1'b0, F3_H, 32'h0A, 32'd0, 32'd0, 32'hFFFFDEAD, ERR_OK, 0);
    do_req("lhu0a", 1'b0, F3_HU, 32'h0A, 32'd0, 32'd0, 32'h0000DEAD, ERR_OK, 0);
    do_req("sh08", 1'b1, F3_H, 32'h08, 32'hCAFE1234, 32'hDEAD1234, 32'd0, ERR_OK, 0);
    check("sh08.mem2", mem[2], 32'hDEAD1234);
    do_req("lh08", 1'b0, F3_H, 32'h08, 32'd0, 32'd0, 32'h00001234, ERR_OK, 0);

    do_req("sw06", 1'b1, F3_W, 32'h06, 32'h11111111, 32'd0, 32'd0, ERR_MISALIGN, 0);
    check("sw06.mem1", mem[1], 32'd0);
    do_req("lh03", 1'b0, F3_H, 32'h03, 32'd0, 32'd0, 32'd0, ERR_MISALIGN, 0);
    do_req("sbu08", 1'b1, F3_BU, 32'h08, 32'h000000AA, 32'd0, 32'd0, ERR_MISALIGN, 0);
    check("sbu08.mem2", mem[2], 32'hDEAD1234);
    do_req("f3_011", 1'b0, 3'b011, 32'h08, 32'd0, 32'd0, 32'd0, ERR_MISALIGN, 0);

    do_req("lw80", 1'b0, F3_W, 32'h80, 32'd0, 32'd0, 32'd0, ERR_RANGE, 0);
    do_req("sw7c", 1'b1, F3_W, 32'h7C, 32'hA5A50F0F, 32'hA5A50F0F, 32'd0, ERR_OK, 0);
    do_req("lw7c", 1'b0, F3_W, 32'h7C, 32'd0, 32'd0, 32'hA5A50F0F, ERR_OK, 0);

    do_req("bp_lw08", 1'b0, F3_W, 32'h08, 32'd0, 32'd0, 32'hDEAD1234, ERR_OK, 3);
    do_req("bp_err", 1'b0, F3_W, 32'h02, 32'd0, 32'd0, 32'd0, ERR_MISALIGN, 3);

    do_req("sw0c", 1'b1, F3_W, 32'h0C, 32'h01020304, 32'h01020304, 32'd0, ERR_OK, 0);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W; req_addr = 32'h0C;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstmid.we_before", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid.mem_we", {31'd0, mem_we}, 32'd0);
    check("rstmid.mem_A", mem_A, 32'd0);
    check("rstmid.mem_WD", mem_WD, 32'd0);
    check("rstmid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstmid.rsp_err", {30'd0, rsp_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rstmid.mem3", mem[3], 32'h01020304);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid.req_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid.rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    do_req("lw0c", 1'b0, F3_W, 32'h0C, 32'd0, 32'd0, 32'h01020304, ERR_OK, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
